// File: rtl/ro_freq_meter_if.sv
// Control/status bundle between the management-side registers and ro_freq_meter.
// cont_i exists only when RO_CONT_EN is defined.
interface ro_freq_meter_if #(
    parameter int SEL_W  = 5,
    parameter int CH_W   = 3,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic [SEL_W-1:0]  sel_i;
    logic [CH_W-1:0]   ch_sel_i;
    logic [GATE_W-1:0] gate_i;
    logic              start_i;
    logic              abort_i;
`ifdef RO_CONT_EN
    logic              cont_i;
`endif
    logic [SEL_W-1:0]  ro_sel_o;
    logic              ro_start_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  count_o;
    logic              ovf_o;

`ifdef RO_CONT_EN
    modport slave (
        input  sel_i, ch_sel_i, gate_i, start_i, abort_i, cont_i,
        output ro_sel_o, ro_start_o, busy_o, done_o, count_o, ovf_o
    );
    modport master (
        output sel_i, ch_sel_i, gate_i, start_i, abort_i, cont_i,
        input  ro_sel_o, ro_start_o, busy_o, done_o, count_o, ovf_o
    );
`else
    modport slave (
        input  sel_i, ch_sel_i, gate_i, start_i, abort_i,
        output ro_sel_o, ro_start_o, busy_o, done_o, count_o, ovf_o
    );
    modport master (
        output sel_i, ch_sel_i, gate_i, start_i, abort_i,
        input  ro_sel_o, ro_start_o, busy_o, done_o, count_o, ovf_o
    );
`endif
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of one selected channel over a gate window.
// Optional continuous back-to-back windows when RO_CONT_EN is defined.
module ro_freq_meter #(
    parameter int NUM_CH = 5,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    parameter int SETTLE = 8    // must be >= 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NUM_CH-1:0] ro_i,
    ro_freq_meter_if.slave    bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STL_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CH_W:0]       NUM_CH_L    = (CH_W + 1)'(NUM_CH);
    localparam logic [STL_W-1:0]    SETTLE_LAST = STL_W'(SETTLE - 1);
    localparam logic [GATE_W-1:0]   GATE_ONE    = GATE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_e;

    state_e            state_q,    state_d;
    logic [SEL_W-1:0]  sel_q,      sel_d;
    logic [CH_W-1:0]   ch_q,       ch_d;
    logic [GATE_W-1:0] gate_q,     gate_d;
    logic [STL_W-1:0]  settle_q,   settle_d;
    logic [GATE_W-1:0] gcnt_q,     gcnt_d;
    logic [CNT_W-1:0]  ecnt_q,     ecnt_d;
    logic              ovf_q,      ovf_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              ovf_out_q,  ovf_out_d;

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic              ro_prev_q;

    logic              ro_cur;
    logic              edge_det;
    logic              cnt_full;
    logic [CNT_W-1:0]  ecnt_inc;
    logic              ovf_inc;
    logic              ch_valid;
    logic              cont_req;
    logic              stay_cont;
    logic              active;

`ifdef RO_CONT_EN
    assign cont_req = bus.cont_i;
`else
    assign cont_req = 1'b0;
`endif

    // Out-of-range channel requests are resolved to channel 0 when latched.
    assign ch_valid = ({1'b0, bus.ch_sel_i} < NUM_CH_L);

    assign ro_cur   = sync2_q[ch_q];
    assign edge_det = ro_cur & ~ro_prev_q;

    assign cnt_full = &ecnt_q;
    assign ecnt_inc = (edge_det && !cnt_full) ? ecnt_q + 1'b1 : ecnt_q;
    assign ovf_inc  = ovf_q | (edge_det & cnt_full);

    assign stay_cont = (state_q == S_DONE) && cont_req && !bus.abort_i;
    assign active    = (state_q == S_SETTLE) || (state_q == S_MEASURE) || stay_cont;

    always_comb begin
        // NOTE: every target gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        ch_d      = ch_q;
        gate_d    = gate_q;
        settle_d  = settle_q;
        gcnt_d    = gcnt_q;
        ecnt_d    = ecnt_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    sel_d    = bus.sel_i;
                    ch_d     = ch_valid ? bus.ch_sel_i : '0;
                    gate_d   = bus.gate_i;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end

            S_SETTLE: begin
                ecnt_d = '0;
                ovf_d  = 1'b0;
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    if (gate_q == '0) begin
                        state_d   = S_DONE;
                        count_d   = '0;
                        ovf_out_d = 1'b0;
                    end else begin
                        state_d = S_MEASURE;
                        gcnt_d  = gate_q;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            S_MEASURE: begin
                ecnt_d = ecnt_inc;
                ovf_d  = ovf_inc;
                gcnt_d = gcnt_q - 1'b1;
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (gcnt_q == GATE_ONE) begin
                    // The edge seen in the last gate cycle is folded into the result.
                    state_d   = S_DONE;
                    count_d   = ecnt_inc;
                    ovf_out_d = ovf_inc;
                end
            end

            S_DONE: begin
                if (stay_cont) begin
                    ecnt_d = '0;
                    ovf_d  = 1'b0;
                    if (gate_q == '0) begin
                        state_d   = S_DONE;
                        count_d   = '0;
                        ovf_out_d = 1'b0;
                    end else begin
                        state_d = S_MEASURE;
                        gcnt_d  = gate_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            ch_q      <= '0;
            gate_q    <= '0;
            settle_q  <= '0;
            gcnt_q    <= '0;
            ecnt_q    <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            ro_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, keeping the synchroniser two stages deep.
            state_q   <= state_d;
            sel_q     <= sel_d;
            ch_q      <= ch_d;
            gate_q    <= gate_d;
            settle_q  <= settle_d;
            gcnt_q    <= gcnt_d;
            ecnt_q    <= ecnt_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            ovf_out_q <= ovf_out_d;
            sync1_q   <= ro_i;
            sync2_q   <= sync1_q;
            ro_prev_q <= ro_cur;
        end
    end

    assign bus.ro_sel_o   = sel_q;
    assign bus.ro_start_o = active;
    assign bus.busy_o     = active;
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.count_o    = count_q;
    assign bus.ovf_o      = ovf_out_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit counter instance and a 4-bit saturation instance.
// Oscillator edges are exactly periodic, so a window that is a whole number of periods has an exact count.
module tb_ro_freq_meter;
    logic       clk;
    logic       rst;
    logic [4:0] ro;
    int         ro_ch;
    int         ro_half;
    int         n_vec;
    int         n_miss;

    ro_freq_meter_if                bus_a ();
    ro_freq_meter_if #(.CNT_W(4))   bus_b ();

    ro_freq_meter u_dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ro_i     (ro),
        .bus      (bus_a.slave)
    );

    ro_freq_meter #(.CNT_W(4)) u_dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ro_i     (ro),
        .bus      (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toggles land 3 units past a multiple of 10, well clear of the posedges at 5 mod 10.
    initial begin
        ro = '0;
        #3;
        forever begin
            if (ro_half == 0) begin
                #10;
            end else begin
                #(ro_half);
                ro[ro_ch] = ~ro[ro_ch];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input bit b);
        return b ? bus_b.done_o : bus_a.done_o;
    endfunction

    function automatic logic get_busy(input bit b);
        return b ? bus_b.busy_o : bus_a.busy_o;
    endfunction

    function automatic logic get_start(input bit b);
        return b ? bus_b.ro_start_o : bus_a.ro_start_o;
    endfunction

    function automatic logic [15:0] get_count(input bit b);
        return b ? {12'b0, bus_b.count_o} : bus_a.count_o;
    endfunction

    function automatic logic get_ovf(input bit b);
        return b ? bus_b.ovf_o : bus_a.ovf_o;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
    task automatic pulse_start(input bit b, input logic [4:0] sel, input logic [2:0] ch,
                               input logic [15:0] gate);
        if (b) begin
            bus_b.sel_i = sel; bus_b.ch_sel_i = ch; bus_b.gate_i = gate; bus_b.start_i = 1'b1;
        end else begin
            bus_a.sel_i = sel; bus_a.ch_sel_i = ch; bus_a.gate_i = gate; bus_a.start_i = 1'b1;
        end
        @(negedge clk);
        bus_a.start_i = 1'b0;
        bus_b.start_i = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int first, output int lat);
        lat = first;
        while (!get_done(b) && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", get_done(b), 1);
    endtask

    task automatic watch_done(input bit b, input int cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (get_done(b)) seen = 1'b1;
        end
    endtask

    task automatic set_ro(input int ch, input int half);
        ro_ch   = ch;
        ro_half = half;
        repeat (20) @(negedge clk);
    endtask

    int lat;
    bit seen;

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        ro_ch   = 0;
        ro_half = 0;
        rst     = 1'b1;
        bus_a.sel_i = '0; bus_a.ch_sel_i = '0; bus_a.gate_i = '0;
        bus_a.start_i = 1'b0; bus_a.abort_i = 1'b0;
        bus_b.sel_i = '0; bus_b.ch_sel_i = '0; bus_b.gate_i = '0;
        bus_b.start_i = 1'b0; bus_b.abort_i = 1'b0;
`ifdef RO_CONT_EN
        bus_a.cont_i = 1'b0;
        bus_b.cont_i = 1'b0;
`endif

        // Reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus_a.busy_o, 0);
        check("rst_done", bus_a.done_o, 0);
        check("rst_ro_start", bus_a.ro_start_o, 0);
        check("rst_ro_sel", bus_a.ro_sel_o, 0);
        check("rst_count", bus_a.count_o, 0);
        check("rst_ovf", bus_a.ovf_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.busy_o) seen = 1'b1;
        end
        check("idle_busy", seen, 0);

        // Basic: channel 2, period 8, gate 800 -> 100 edges
        set_ro(2, 40);
        pulse_start(1'b0, 5'h15, 3'd2, 16'd800);
        check("settle_ro_sel", bus_a.ro_sel_o, 5'h15);
        check("settle_ro_start", bus_a.ro_start_o, 1);
        check("settle_busy", bus_a.busy_o, 1);
        wait_done(1'b0, 1, lat);
        check("basic_latency", lat, 809);
        check("basic_count", bus_a.count_o, 100);
        check("basic_ovf", bus_a.ovf_o, 0);
        check("done_ro_start", bus_a.ro_start_o, 0);
        check("done_busy", bus_a.busy_o, 0);
        @(negedge clk);
        check("after_done_pulse", bus_a.done_o, 0);

        // Out-of-range channel 7 measures channel 0: period 10, gate 100 -> 10 edges
        set_ro(0, 50);
        pulse_start(1'b0, 5'h03, 3'd7, 16'd100);
        wait_done(1'b0, 1, lat);
        check("badch_latency", lat, 109);
        check("badch_count", bus_a.count_o, 10);

        // Zero gate with simultaneous abort in IDLE: start wins, DONE right after SETTLE
        @(negedge clk);
        bus_a.abort_i = 1'b1;
        pulse_start(1'b0, 5'h01, 3'd0, 16'd0);
        bus_a.abort_i = 1'b0;
        check("zero_busy", bus_a.busy_o, 1);
        wait_done(1'b0, 1, lat);
        check("zero_latency", lat, 9);
        check("zero_count", bus_a.count_o, 0);
        check("zero_ovf", bus_a.ovf_o, 0);

        // Start during MEASURE and during DONE is ignored
        @(negedge clk);
        pulse_start(1'b0, 5'h09, 3'd0, 16'd100);
        repeat (29) @(negedge clk);
        pulse_start(1'b0, 5'h02, 3'd0, 16'd10);
        check("ign_ro_sel", bus_a.ro_sel_o, 5'h09);
        wait_done(1'b0, 31, lat);
        check("ign_latency", lat, 109);
        check("ign_count", bus_a.count_o, 10);
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        check("ign_done_start_busy", bus_a.busy_o, 0);
        watch_done(1'b0, 150, seen);
        check("ign_single_done", seen, 0);

        // Saturation on the 4-bit instance: period 4, gate 200 -> 50 edges
        set_ro(1, 20);
        pulse_start(1'b1, 5'h00, 3'd1, 16'd200);
        wait_done(1'b1, 1, lat);
        check("sat_latency", lat, 209);
        check("sat_count", get_count(1'b1), 15);
        check("sat_ovf", get_ovf(1'b1), 1);

        // Abort at MEASURE cycle 50: no done, result registers untouched
        @(negedge clk);
        pulse_start(1'b1, 5'h00, 3'd1, 16'd400);
        repeat (57) @(negedge clk);
        check("abort_pre_busy", get_busy(1'b1), 1);
        bus_b.abort_i = 1'b1;
        @(negedge clk);
        bus_b.abort_i = 1'b0;
        check("abort_busy", get_busy(1'b1), 0);
        check("abort_ro_start", get_start(1'b1), 0);
        watch_done(1'b1, 450, seen);
        check("abort_no_done", seen, 0);
        check("abort_count_kept", get_count(1'b1), 15);
        check("abort_ovf_kept", get_ovf(1'b1), 1);

        // Short window after saturation: 20 cycles / period 4 -> 5 edges, ovf cleared
        pulse_start(1'b1, 5'h00, 3'd1, 16'd20);
        wait_done(1'b1, 1, lat);
        check("short_latency", lat, 29);
        check("short_count", get_count(1'b1), 5);
        check("short_ovf", get_ovf(1'b1), 0);

        // Reset mid-measurement clears everything at once
        set_ro(0, 50);
        pulse_start(1'b0, 5'h1f, 3'd0, 16'd500);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", bus_a.busy_o, 0);
        check("rstmid_ro_start", bus_a.ro_start_o, 0);
        check("rstmid_ro_sel", bus_a.ro_sel_o, 0);
        check("rstmid_count", bus_a.count_o, 0);
        @(negedge clk);
        rst = 1'b0;
        watch_done(1'b0, 600, seen);
        check("rstmid_no_done", seen, 0);

`ifdef RO_CONT_EN
        // Continuous windows: done every 101 cycles, 10 edges each, then drop cont_i
        bus_a.cont_i = 1'b1;
        pulse_start(1'b0, 5'h04, 3'd0, 16'd100);
        wait_done(1'b0, 1, lat);
        check("cont_first_latency", lat, 109);
        check("cont_first_count", bus_a.count_o, 10);
        check("cont_first_ro_start", bus_a.ro_start_o, 1);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            if (w == 2) bus_a.cont_i = 1'b0;
            wait_done(1'b0, 1, lat);
            check("cont_interval", lat, 101);
            check("cont_count", bus_a.count_o, 10);
            check("cont_ro_start", bus_a.ro_start_o, (w < 2) ? 1 : 0);
        end
        @(negedge clk);
        check("cont_end_busy", bus_a.busy_o, 0);
        check("cont_end_ro_start", bus_a.ro_start_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
